// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational 4-bit ALU among NUM_REQ
// requesters, with a single registered, ID-tagged response slot.
module alu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_A,
  input  logic [4*NUM_REQ-1:0]   req_B,
  input  logic [2*NUM_REQ-1:0]   req_opcode,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [3:0]             alu_A,
  output logic [3:0]             alu_B,
  output logic [1:0]             alu_opcode,
  input  logic [3:0]             alu_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [3:0]             rsp_result,
  output logic                   rsp_zero
);

  logic [ID_W-1:0] r_ptr;
  logic            r_valid;
  logic [ID_W-1:0] r_id;
  logic [3:0]      r_result;
  logic            r_zero;

  logic [3:0]      w_a  [NUM_REQ];
  logic [3:0]      w_b  [NUM_REQ];
  logic [1:0]      w_op [NUM_REQ];

  logic            w_found;
  logic [ID_W-1:0] w_gnt;
  logic [ID_W-1:0] w_cand;
  logic            w_can;
  logic            w_accept;
  logic [ID_W-1:0] w_ptr_nxt;

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a[gi]  = req_A[4*gi +: 4];
    assign w_b[gi]  = req_B[4*gi +: 4];
    assign w_op[gi] = req_opcode[2*gi +: 2];
  end

  // Search from r_ptr upward; with no winner w_gnt stays at r_ptr.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = r_ptr;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gnt   = w_cand;
      end
    end
  end

  assign w_can    = !r_valid || rsp_ready;
  assign w_accept = w_can && w_found;

  assign w_ptr_nxt = (w_gnt == ID_W'(NUM_REQ-1))
                   ? '0 : w_gnt + 1'b1;

  always_comb begin
    req_ready = '0;
    if (w_accept)
      req_ready[w_gnt] = 1'b1;
  end

  assign alu_A      = w_a[w_gnt];
  assign alu_B      = w_b[w_gnt];
  assign alu_opcode = w_op[w_gnt];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ptr    <= '0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_id     <= w_gnt;
      r_result <= alu_result;
      r_zero   <= (alu_result == 4'h0);
      r_ptr    <= w_ptr_nxt;
    end else if (rsp_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign rsp_valid  = r_valid;
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed, scoreboard-checked bench for alu_rr_arbiter
// with a behavioural 4-bit ALU on the shared port.
module tb_alu_rr_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [4*N-1:0] req_A;
  logic [4*N-1:0] req_B;
  logic [2*N-1:0] req_opcode;
  logic [N-1:0] req_ready;
  logic [3:0]   alu_A;
  logic [3:0]   alu_B;
  logic [1:0]   alu_opcode;
  logic [3:0]   alu_result;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [3:0]   rsp_result;
  logic         rsp_zero;

  alu_rr_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_A(req_A),
    .req_B(req_B), .req_opcode(req_opcode),
    .req_ready(req_ready),
    .alu_A(alu_A), .alu_B(alu_B),
    .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] alu4(
    input logic [3:0] a, input logic [3:0] b,
    input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  always_comb alu_result = alu4(alu_A, alu_B, alu_opcode);

  logic [3:0] ta  [N];
  logic [3:0] tb_ [N];
  logic [1:0] top [N];

  always_comb begin
    req_A = '0;
    req_B = '0;
    req_opcode = '0;
    for (int i = 0; i < N; i++) begin
      req_A[4*i +: 4]      = ta[i];
      req_B[4*i +: 4]      = tb_[i];
      req_opcode[2*i +: 2] = top[i];
    end
  end

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] res;
    logic       z;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   m_ptr    = 0;
  bit   m_valid  = 0;
  logic [N-1:0] last_rdy;

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] a,
                         input logic [3:0] b,
                         input logic [1:0] op);
    ta[i] = a;
    tb_[i] = b;
    top[i] = op;
  endtask

  // One clock: drive, check against the model, advance to next negedge.
  task automatic cycle(input logic [N-1:0] v, input logic rr);
    int g;
    int sel;
    bit can;
    logic [N-1:0] er;
    exp_t e;
    req_valid = v;
    rsp_ready = rr;
    #1;
    can = !m_valid || rr;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    er = (can && g >= 0) ? (N'(1) << g) : '0;
    last_rdy = req_ready;
    check("req_ready", 8'(req_ready), 8'(er));
    sel = (g >= 0) ? g : m_ptr;
    check("alu_A", 8'(alu_A), 8'(ta[sel]));
    check("alu_B", 8'(alu_B), 8'(tb_[sel]));
    check("alu_op", 8'(alu_opcode), 8'(top[sel]));
    check("rsp_valid", 8'(rsp_valid), 8'(m_valid));
    if (m_valid) begin
      if (q.size() == 0) begin
        check("sb_nonempty", 8'(q.size()), 8'd1);
      end else begin
        check("rsp_id", 8'(rsp_id), 8'(q[0].id));
        check("rsp_result", 8'(rsp_result), 8'(q[0].res));
        check("rsp_zero", 8'(rsp_zero), 8'(q[0].z));
        if (rr) void'(q.pop_front());
      end
    end
    if (can && g >= 0) begin
      e.id  = 2'(g);
      e.res = alu4(ta[g], tb_[g], top[g]);
      e.z   = (e.res == 4'h0);
      q.push_back(e);
    end
    @(posedge clk);
    if (can && g >= 0) begin
      m_valid = 1;
      m_ptr = (g + 1) % N;
    end else if (rr) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", 8'(rsp_valid), 8'd0);
    check("rst_result", 8'(rsp_result), 8'd0);
    check("rst_id", 8'(rsp_id), 8'd0);
    check("rst_zero", 8'(rsp_zero), 8'd0);
    rst = 1'b0;
    m_valid = 0;
    m_ptr = 0;
    q.delete();
  endtask

  logic [N-1:0] rr_g [5];
  logic [3:0]   rr_r [5];

  initial begin
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 4'h0, 4'h0, 2'b00);
    @(posedge clk);
    @(negedge clk);
    do_reset();
    req_valid = '0;
    #1;
    check("idle_ready", 8'(req_ready), 8'd0);

    // Single request: F+1 wraps to 0.
    set_req(2, 4'hF, 4'h1, 2'b00);
    cycle(4'b0100, 1'b1);
    check("single_id", 8'(rsp_id), 8'd2);
    check("single_res", 8'(rsp_result), 8'h0);
    check("single_zero", 8'(rsp_zero), 8'd1);
    cycle(4'b0000, 1'b1);

    // Round robin from ptr 0 with all four valid.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 4'(i), 4'h3, 2'b01);
    rr_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_r = '{4'hD, 4'hE, 4'hF, 4'h0, 4'hD};
    for (int s = 0; s < 5; s++) begin
      cycle(4'b1111, 1'b1);
      check("rr_grant", 8'(last_rdy), 8'(rr_g[s]));
      check("rr_result", 8'(rsp_result), 8'(rr_r[s]));
    end
    cycle(4'b0000, 1'b1);

    // Backpressure: fill, stall 3 cycles, then same-cycle drain+accept.
    cycle(4'b0001, 1'b0);
    for (int s = 0; s < 3; s++) begin
      cycle(4'b1010, 1'b0);
      check("bp_ready", 8'(last_rdy), 8'd0);
      check("bp_valid", 8'(rsp_valid), 8'd1);
      check("bp_id", 8'(rsp_id), 8'd0);
    end
    cycle(4'b1010, 1'b1);
    check("bp_grant1", 8'(last_rdy), 8'b0010);
    check("bp_nodip", 8'(rsp_valid), 8'd1);
    check("bp_newid", 8'(rsp_id), 8'd1);
    cycle(4'b1000, 1'b1);
    check("bp_grant3", 8'(last_rdy), 8'b1000);
    cycle(4'b0000, 1'b1);

    // Fairness: 0 and 3 alternate.
    for (int s = 0; s < 6; s++) begin
      cycle(4'b1001, 1'b1);
      check("fair_grant", 8'(last_rdy),
            (s % 2 == 0) ? 8'b0001 : 8'b1000);
    end
    cycle(4'b0000, 1'b1);

    // AND / OR.
    set_req(1, 4'hC, 4'hA, 2'b10);
    cycle(4'b0010, 1'b1);
    check("and_res", 8'(rsp_result), 8'h8);
    check("and_zero", 8'(rsp_zero), 8'd0);
    set_req(1, 4'hC, 4'hA, 2'b11);
    cycle(4'b0010, 1'b1);
    check("or_res", 8'(rsp_result), 8'hE);
    check("or_zero", 8'(rsp_zero), 8'd0);
    cycle(4'b0000, 1'b1);

    // Reset while FULL with ptr at 2.
    cycle(4'b0010, 1'b0);
    check("pre_rst_full", 8'(rsp_valid), 8'd1);
    req_valid = '0;
    do_reset();
    cycle(4'b1111, 1'b1);
    check("post_rst_grant", 8'(last_rdy), 8'b0001);
    cycle(4'b0000, 1'b1);
    check("sb_empty", 8'(q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
